// File: rtl/opl_timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// opl_timer_ctrl_if
//   Bundles the host CPU bus, the forwarded register-write stream and the
//   two timer control/overflow lines of opl_timer_ctrl.
//   master : host/core side (drives cs/wr/a0/din and the overflow pulses)
//   slave  : opl_timer_ctrl (drives status, irq, reg-write stream, timer ctl)
//   Signals:
//     cs, wr, a0, din          host write strobe, address/data select, data
//     dout, irq_n              status byte and active-low interrupt
//     reg_wr/reg_addr/reg_data one-cycle forwarded data write
//     timerN_init/timerN_start timer reload value and run level
//     timerN_overflow          one-cycle overflow pulse from each timer
// ---------------------------------------------------------------------------
interface opl_timer_ctrl_if #(
  parameter int REG_TIMER_WIDTH = 8
);
  logic                       cs;
  logic                       wr;
  logic                       a0;
  logic [7:0]                 din;
  logic [7:0]                 dout;
  logic                       irq_n;
  logic                       reg_wr;
  logic [7:0]                 reg_addr;
  logic [7:0]                 reg_data;
  logic [REG_TIMER_WIDTH-1:0] timer1_init;
  logic [REG_TIMER_WIDTH-1:0] timer2_init;
  logic                       timer1_start;
  logic                       timer2_start;
  logic                       timer1_overflow;
  logic                       timer2_overflow;

  modport master (
    output cs, wr, a0, din, timer1_overflow, timer2_overflow,
    input  dout, irq_n, reg_wr, reg_addr, reg_data,
           timer1_init, timer2_init, timer1_start, timer2_start
  );

  modport slave (
    input  cs, wr, a0, din, timer1_overflow, timer2_overflow,
    output dout, irq_n, reg_wr, reg_addr, reg_data,
           timer1_init, timer2_init, timer1_start, timer2_start
  );
endinterface

// File: rtl/opl_timer_ctrl.sv
// ---------------------------------------------------------------------------
// opl_timer_ctrl
//   Host register front end and interrupt controller for the two OPL2 timers.
//   Decodes address/data writes, owns registers 0x02/0x03/0x04, forwards
//   every data write to the core and keeps the sticky FT1/FT2 flags + IRQ.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      opl_timer_ctrl_if.slave (host bus, reg-write stream, timers)
//   Parameters:
//     STATUS_FILL      constant on status bits [4:0]
//     REG_TIMER_WIDTH  width of the timer init registers
// ---------------------------------------------------------------------------

// Per-timer sticky overflow flag. ft_nxt_o is exposed so the IRQ line can be
// registered from the same next-state as the flag itself.
module opl_timer_ctrl_flag (
  input  logic clk,
  input  logic reset_n,
  input  logic ovf_i,      // overflow pulse from the timer
  input  logic mask_i,     // effective mask for this cycle (new value on write)
  input  logic clr_i,      // RST write
  output logic ft_nxt_o,
  output logic ft_o
);
  logic ft_q, ft_d;

  // An overflow in the same cycle as RST wins; masked overflows are dropped.
  assign ft_d     = (ft_q & ~clr_i) | (ovf_i & ~mask_i);
  assign ft_nxt_o = ft_d;
  assign ft_o     = ft_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ft_q <= 1'b0;
    else          ft_q <= ft_d;
  end
endmodule

module opl_timer_ctrl #(
  parameter logic [4:0] STATUS_FILL     = 5'h06,
  parameter int         REG_TIMER_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  opl_timer_ctrl_if.slave  bus
);
  localparam int NUM_TIMERS = 2;
  localparam logic [7:0] ADDR_T1   = 8'h02;
  localparam logic [7:0] ADDR_T2   = 8'h03;
  localparam logic [7:0] ADDR_CTRL = 8'h04;

  // index 0 = timer 1, index 1 = timer 2
  logic                                        wr_q;
  logic [7:0]                                  addr_q, addr_d;
  logic [NUM_TIMERS-1:0][REG_TIMER_WIDTH-1:0]  init_q, init_d;
  logic [NUM_TIMERS-1:0]                       start_q, start_d;
  logic [NUM_TIMERS-1:0]                       mask_q, mask_d;
  logic                                        reg_wr_q, reg_wr_d;
  logic [7:0]                                  reg_addr_q, reg_addr_d;
  logic [7:0]                                  reg_data_q, reg_data_d;
  logic                                        irq_n_q;

  logic                                        commit;
  logic                                        data_commit;
  logic                                        flag_clr;
  logic [NUM_TIMERS-1:0]                       ovf;
  logic [NUM_TIMERS-1:0]                       ft_d, ft_q;

  // One commit per rising edge of (cs & wr); dropping cs re-arms it.
  assign commit      = bus.cs & bus.wr & ~wr_q;
  assign data_commit = commit & bus.a0;
  assign ovf         = {bus.timer2_overflow, bus.timer1_overflow};

  always_comb begin
    addr_d     = addr_q;
    init_d     = init_q;
    start_d    = start_q;
    mask_d     = mask_q;
    flag_clr   = 1'b0;
    reg_wr_d   = data_commit;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;

    if (commit && !bus.a0) addr_d = bus.din;

    if (data_commit) begin
      // Every data write is forwarded, including the timer registers.
      reg_addr_d = addr_q;
      reg_data_d = bus.din;
      unique case (addr_q)
        ADDR_T1: init_d[0] = REG_TIMER_WIDTH'(bus.din);
        ADDR_T2: init_d[1] = REG_TIMER_WIDTH'(bus.din);
        ADDR_CTRL: begin
          if (bus.din[7]) begin
            // RST only clears flags; masks and starts untouched.
            flag_clr = 1'b1;
          end else begin
            mask_d  = {bus.din[5], bus.din[6]};
            start_d = bus.din[1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // mask_d (not mask_q) feeds the flags so a mask written in the same cycle
  // as an overflow already suppresses it.
  for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_flag
    opl_timer_ctrl_flag u_flag (
      .clk      (clk),
      .reset_n  (reset_n),
      .ovf_i    (ovf[t]),
      .mask_i   (mask_d[t]),
      .clr_i    (flag_clr),
      .ft_nxt_o (ft_d[t]),
      .ft_o     (ft_q[t])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      init_q     <= '0;
      start_q    <= '0;
      mask_q     <= '0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      irq_n_q    <= 1'b1;
    end else begin
      wr_q       <= bus.cs & bus.wr;
      addr_q     <= addr_d;
      init_q     <= init_d;
      start_q    <= start_d;
      mask_q     <= mask_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      // Built from next-state flags so it moves on the same edge as FT1/FT2.
      irq_n_q    <= ~(|ft_d);
    end
  end

  assign bus.dout         = {(|ft_q), ft_q[0], ft_q[1], STATUS_FILL};
  assign bus.irq_n        = irq_n_q;
  assign bus.reg_wr       = reg_wr_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_data     = reg_data_q;
  assign bus.timer1_init  = init_q[0];
  assign bus.timer2_init  = init_q[1];
  assign bus.timer1_start = start_q[0];
  assign bus.timer2_start = start_q[1];
endmodule
